// File: rtl/spart_bus_arb_if.sv
// Requester-side and SPART-side signal bundle for spart_bus_arb.
// master: requesters plus the SPART environment; slave: the arbiter.
interface spart_bus_arb_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [2*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic [7:0]           rdata;
    logic                 rda;
    logic                 tbr;
    logic                 iocs;
    logic                 iorw;
    logic [1:0]           ioaddr;
    logic [7:0]           dbus_out;
    logic                 dbus_oe;
    logic [7:0]           dbus_in;

    modport master (
        output req, req_rw, req_addr, req_wdata, rda, tbr, dbus_in,
        input  gnt, done, err, rdata, iocs, iorw, ioaddr, dbus_out, dbus_oe
    );

    modport slave (
        input  req, req_rw, req_addr, req_wdata, rda, tbr, dbus_in,
        output gnt, done, err, rdata, iocs, iorw, ioaddr, dbus_out, dbus_oe
    );
endinterface

// File: rtl/spart_bus_arb.sv
// Round-robin arbiter sharing the SPART processor bus, one bus cycle per grant.
// Optional SPART_ARB_TIMEOUT_EN aborts a grant stuck waiting for rda/tbr.
module spart_bus_arb #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input logic             clk,
    input logic             rst,
    spart_bus_arb_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("spart_bus_arb: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, GRANT, BUS, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic                 rw_q, rw_d;
    logic [1:0]           addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 iocs_q, iocs_d;
    logic                 iorw_q, iorw_d;
    logic [1:0]           ioaddr_q, ioaddr_d;
    logic [7:0]           dbus_out_q, dbus_out_d;
    logic                 dbus_oe_q, dbus_oe_d;

    logic [IDX_W-1:0]     pick;
    logic                 any_req;
    logic                 sel_rw;
    logic [1:0]           sel_addr;
    logic [7:0]           sel_wdata;
    logic                 win_req;
    logic                 ready;

`ifdef SPART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
`endif

    // Scan downward so the last hit is the nearest requester after the pointer.
    always_comb begin
        int c;
        c       = 0;
        pick    = ptr_q;
        any_req = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            c = int'(ptr_q) + i;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (bus.req[c[IDX_W-1:0]]) begin
                pick    = c[IDX_W-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        win_req   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                sel_rw    = bus.req_rw[i];
                sel_addr  = bus.req_addr[2*i +: 2];
                sel_wdata = bus.req_wdata[8*i +: 8];
            end
            if (win_q == IDX_W'(i)) win_req = bus.req[i];
        end
    end

    // Only the data register is gated; status and divisor registers are always accessible.
    assign ready = (addr_q != 2'd0) || (rw_q ? bus.rda : bus.tbr);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        rdata_d    = rdata_q;
        iocs_d     = 1'b0;
        iorw_d     = 1'b1;
        ioaddr_d   = ioaddr_q;
        dbus_out_d = dbus_out_q;
        dbus_oe_d  = 1'b0;
`ifdef SPART_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    win_d   = pick;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    gnt_d   = NUM_REQ'(1) << pick;
                    state_d = GRANT;
`ifdef SPART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (!win_req) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (ready) begin
                    iocs_d    = 1'b1;
                    iorw_d    = rw_q;
                    ioaddr_d  = addr_q;
                    dbus_oe_d = !rw_q;
                    if (!rw_q) dbus_out_d = wdata_q;
                    state_d   = BUS;
                end
`ifdef SPART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                    rdata_d = 8'hFF;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            BUS: begin
                done_d  = gnt_q;
                if (rw_q) rdata_d = bus.dbus_in;
                state_d = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            win_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= '0;
            dbus_out_q <= '0;
            dbus_oe_q  <= 1'b0;
`ifdef SPART_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            iocs_q     <= iocs_d;
            iorw_q     <= iorw_d;
            ioaddr_q   <= ioaddr_d;
            dbus_out_q <= dbus_out_d;
            dbus_oe_q  <= dbus_oe_d;
`ifdef SPART_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.iocs     = iocs_q;
    assign bus.iorw     = iorw_q;
    assign bus.ioaddr   = ioaddr_q;
    assign bus.dbus_out = dbus_out_q;
    assign bus.dbus_oe  = dbus_oe_q;
`ifdef SPART_ARB_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = 1'b0;
`endif
endmodule

// File: tb/tb_spart_bus_arb.sv
// Bench for spart_bus_arb: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a timestamp-based transaction model.
module tb_spart_bus_arb;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spart_bus_arb_if #(.NUM_REQ(NR)) bif();

    spart_bus_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    bit         rq   [NR];
    bit         rrw  [NR];
    logic [1:0] radr [NR];
    logic [7:0] rwd  [NR];

    int seq [4];
    int nd, ndone, niocs;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            bif.req[i]            = rq[i];
            bif.req_rw[i]         = rrw[i];
            bif.req_addr[2*i +: 2]  = radr[i];
            bif.req_wdata[8*i +: 8] = rwd[i];
        end
    endtask

    task automatic set_req(int i, bit on, bit rw, logic [1:0] a, logic [7:0] d);
        rq[i] = on; rrw[i] = rw; radr[i] = a; rwd[i] = d;
        apply();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rq[i] = 1'b0; rrw[i] = 1'b0; radr[i] = 2'd0; rwd[i] = 8'd0;
        end
        bif.rda = 1'b0; bif.tbr = 1'b0; bif.dbus_in = 8'd0;
        apply();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Transaction model: one active grant with the edge at which it reached the bus.
    int              edge_no = 0;
    bit              m_act = 1'b0;
    int              m_own, m_ptr, m_bus_edge, m_c;
    bit              m_found, m_rw;
    logic [1:0]      m_addr;
    logic [7:0]      m_wd;
    logic [NR-1:0]   exp_gnt, exp_done;
    logic            exp_err, exp_iocs, exp_iorw, exp_oe;
    logic [1:0]      exp_ioaddr;
    logic [7:0]      exp_rdata, exp_dout;

    always @(posedge clk) begin
        edge_no++;
        if (rst) begin
            m_act = 1'b0; m_ptr = NR - 1; m_bus_edge = -1;
            exp_gnt = '0; exp_done = '0; exp_err = 1'b0; exp_rdata = 8'd0;
            exp_iocs = 1'b0; exp_iorw = 1'b1; exp_ioaddr = 2'd0;
            exp_dout = 8'd0; exp_oe = 1'b0;
        end else begin
            if (!m_act) begin
                if (bif.req != '0) begin
                    m_found = 1'b0;
                    for (int k = 1; k <= NR; k++) begin
                        m_c = (m_ptr + k) % NR;
                        if (!m_found && bif.req[m_c]) begin
                            m_found = 1'b1; m_own = m_c;
                        end
                    end
                    m_act = 1'b1; m_bus_edge = -1;
                    m_rw = bif.req_rw[m_own];
                    m_addr = bif.req_addr[2*m_own +: 2];
                    m_wd = bif.req_wdata[8*m_own +: 8];
                end
            end else if (m_bus_edge < 0) begin
                if (!bif.req[m_own]) m_act = 1'b0;
                else if (m_addr != 2'd0 || (m_rw ? bif.rda : bif.tbr)) m_bus_edge = edge_no;
            end else if (edge_no == m_bus_edge + 1) begin
                if (m_rw) exp_rdata = bif.dbus_in;
            end else begin
                m_act = 1'b0; m_ptr = m_own;
            end
            exp_gnt  = m_act ? (NR'(1) << m_own) : '0;
            exp_iocs = m_act && (m_bus_edge == edge_no);
            exp_done = (m_act && m_bus_edge >= 0 && edge_no == m_bus_edge + 1) ? (NR'(1) << m_own) : '0;
            exp_err  = 1'b0;
            exp_oe   = exp_iocs && !m_rw;
            exp_iorw = exp_iocs ? m_rw : 1'b1;
            if (exp_iocs) begin
                exp_ioaddr = m_addr;
                if (!m_rw) exp_dout = m_wd;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_gnt", 32'(bif.gnt), 32'(exp_gnt));
            check("m_done", 32'(bif.done), 32'(exp_done));
            check("m_err", 32'(bif.err), 32'(exp_err));
            check("m_rdata", 32'(bif.rdata), 32'(exp_rdata));
            check("m_iocs", 32'(bif.iocs), 32'(exp_iocs));
            check("m_iorw", 32'(bif.iorw), 32'(exp_iorw));
            check("m_ioaddr", 32'(bif.ioaddr), 32'(exp_ioaddr));
            check("m_dbus_out", 32'(bif.dbus_out), 32'(exp_dout));
            check("m_dbus_oe", 32'(bif.dbus_oe), 32'(exp_oe));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("rst_gnt", 32'(bif.gnt), 0);
        check("rst_done", 32'(bif.done), 0);
        check("rst_rdata", 32'(bif.rdata), 0);
        check("rst_iocs", 32'(bif.iocs), 0);
        check("rst_iorw", 32'(bif.iorw), 1);
        check("rst_oe", 32'(bif.dbus_oe), 0);

        // Single write to divisor lo
        set_req(0, 1'b1, 1'b0, 2'd2, 8'h80);
        @(negedge clk);
        check("t1_gnt", 32'(bif.gnt), 32'h1);
        check("t1_iocs_early", 32'(bif.iocs), 0);
        @(negedge clk);
        check("t1_iocs", 32'(bif.iocs), 1);
        check("t1_iorw", 32'(bif.iorw), 0);
        check("t1_ioaddr", 32'(bif.ioaddr), 2);
        check("t1_oe", 32'(bif.dbus_oe), 1);
        check("t1_dout", 32'(bif.dbus_out), 32'h80);
        @(negedge clk);
        check("t1_done", 32'(bif.done), 32'h1);
        check("t1_err", 32'(bif.err), 0);
        set_req(0, 1'b0, 1'b0, 2'd2, 8'h80);
        @(negedge clk);
        check("t1_gnt_clr", 32'(bif.gnt), 0);

        // Two requesters continuously writing addr 3 must alternate
        do_reset();
        set_req(0, 1'b1, 1'b0, 2'd3, 8'h11);
        set_req(1, 1'b1, 1'b0, 2'd3, 8'h22);
        seq = '{99, 99, 99, 99};
        nd = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (nd < 4 && bif.done != '0) begin
                seq[nd] = (bif.done == 3'b001) ? 0 : (bif.done == 3'b010) ? 1 : 9;
                nd++;
            end
        end
        check("t2_count", nd, 4);
        for (int k = 0; k < 4; k++) check("t2_order", seq[k], k % 2);
        set_req(0, 1'b0, 1'b0, 2'd3, 8'h11);
        set_req(1, 1'b0, 1'b0, 2'd3, 8'h22);
        repeat (4) @(negedge clk);

        // Data read waits for rda
        do_reset();
        set_req(1, 1'b1, 1'b1, 2'd0, 8'h00);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("t3_wait_iocs", 32'(bif.iocs), 0);
            check("t3_wait_gnt", 32'(bif.gnt), 32'h2);
        end
        bif.rda = 1'b1; bif.dbus_in = 8'h5A;
        @(negedge clk);
        check("t3_iocs", 32'(bif.iocs), 1);
        check("t3_iorw", 32'(bif.iorw), 1);
        check("t3_oe", 32'(bif.dbus_oe), 0);
        @(negedge clk);
        check("t3_done", 32'(bif.done), 32'h2);
        check("t3_rdata", 32'(bif.rdata), 32'h5A);
        set_req(1, 1'b0, 1'b1, 2'd0, 8'h00);
        bif.rda = 1'b0;
        @(negedge clk);
        check("t3_iocs_off", 32'(bif.iocs), 0);

        // Cancel by dropping req while waiting for tbr; pointer must not move
        do_reset();
        set_req(0, 1'b1, 1'b0, 2'd0, 8'h44);
        repeat (3) begin
            @(negedge clk);
            check("t4_wait_iocs", 32'(bif.iocs), 0);
        end
        set_req(0, 1'b0, 1'b0, 2'd0, 8'h44);
        @(negedge clk);
        check("t4_gnt_clr", 32'(bif.gnt), 0);
        check("t4_no_done", 32'(bif.done), 0);
        bif.tbr = 1'b1;
        set_req(0, 1'b1, 1'b0, 2'd0, 8'h45);
        set_req(1, 1'b1, 1'b0, 2'd0, 8'h46);
        @(negedge clk);
        check("t4_rewin", 32'(bif.gnt), 32'h1);
        @(negedge clk);
        check("t4_dout", 32'(bif.dbus_out), 32'h45);
        @(negedge clk);
        check("t4_done", 32'(bif.done), 32'h1);
        set_req(0, 1'b0, 1'b0, 2'd0, 8'h45);
        set_req(1, 1'b0, 1'b0, 2'd0, 8'h46);
        repeat (3) @(negedge clk);

        // Reset during the bus cycle of a read
        do_reset();
        bif.dbus_in = 8'h33;
        set_req(0, 1'b1, 1'b1, 2'd1, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("t5_in_bus", 32'(bif.iocs), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_gnt", 32'(bif.gnt), 0);
        check("t5_done", 32'(bif.done), 0);
        check("t5_iocs", 32'(bif.iocs), 0);
        check("t5_iorw", 32'(bif.iorw), 1);
        check("t5_ioaddr", 32'(bif.ioaddr), 0);
        check("t5_rdata", 32'(bif.rdata), 0);
        rst = 1'b0;
        set_req(0, 1'b0, 1'b1, 2'd1, 8'h00);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (bif.done != '0) ndone++;
        end
        check("t5_no_done_after", ndone, 0);

        // Without the timeout feature a blocked data write waits indefinitely
        do_reset();
        set_req(0, 1'b1, 1'b0, 2'd0, 8'h77);
        ndone = 0; niocs = 0;
        repeat (120) begin
            @(negedge clk);
            if (bif.done != '0) ndone++;
            if (bif.iocs) niocs++;
        end
        check("t6_no_done", ndone, 0);
        check("t6_no_iocs", niocs, 0);
        check("t6_gnt_held", 32'(bif.gnt), 32'h1);
        set_req(0, 1'b0, 1'b0, 2'd0, 8'h77);
        repeat (2) @(negedge clk);

        // Randomized traffic; the per-cycle compare process does the checking
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NR; i++) begin
                if (rq[i]) begin
                    if (exp_done[i]) begin
                        if ($urandom_range(0, 1) == 0) rq[i] = 1'b0;
                        else begin
                            rrw[i] = 1'($urandom); radr[i] = 2'($urandom); rwd[i] = 8'($urandom);
                        end
                    end else if ($urandom_range(0, 31) == 0) begin
                        rq[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rq[i] = 1'b1;
                    rrw[i] = 1'($urandom); radr[i] = 2'($urandom); rwd[i] = 8'($urandom);
                end
            end
            bif.rda = ($urandom_range(0, 3) != 0);
            bif.tbr = ($urandom_range(0, 3) != 0);
            bif.dbus_in = 8'($urandom);
            apply();
        end
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spart_bus_arb.md
Name: spart_bus_arb

Overview:
- Shares the single SPART processor-side bus (iocs/iorw/ioaddr/databus) between NUM_REQ requesters, e.g. the baud-config sequencer and byte-stream clients.
- Arbitrates round-robin, gates data-register accesses on SPART readiness (tbr for writes, rda for reads), and runs exactly one one-cycle bus transaction per grant.
- Sits between the requesters and the SPART; the top level owns the databus tristate, built from dbus_out/dbus_oe.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 255, maximum GRANT-wait cycles before abort; used only with SPART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester transaction request, level
- req_rw  in  NUM_REQ  1=read, 0=write
- req_addr  in  2*NUM_REQ  ioaddr per requester; 0=data, 1=status, 2=divisor lo, 3=divisor hi
- req_wdata  in  8*NUM_REQ  write data per requester
- gnt  out  NUM_REQ  one-hot grant, registered
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- err  out  1  valid with done; 1 means the transaction was aborted
- rdata  out  8  read data, valid while done is high
- rda  in  1  SPART receive data available
- tbr  in  1  SPART transmit buffer ready
- iocs  out  1  SPART chip select
- iorw  out  1  1=read, 0=write
- ioaddr  out  2  SPART register address
- dbus_out  out  8  write data toward databus
- dbus_oe  out  1  arbiter drives databus
- dbus_in  in  8  databus sampled value

Behaviour:
- Reset values (rst high at a clk edge):
  - state=IDLE; gnt=0; done=0; err=0; rdata=0.
  - iocs=0; iorw=1; ioaddr=0; dbus_out=0; dbus_oe=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transaction aborts it silently: no done pulse.
- States: IDLE, GRANT, BUS, DONE. All outputs are registered.
- IDLE:
  - If any req is high, select the first requester after the pointer with req high (wrapping).
  - Latch its rw, addr and wdata; set gnt[winner]; go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - If req[winner] drops, clear gnt and return to IDLE. No done; pointer unchanged.
  - Ready condition:
    - addr=0 read needs rda=1.
    - addr=0 write needs tbr=1.
    - addr 1..3 are always ready.
  - If ready, go to BUS; else stay.
- BUS (exactly one cycle):
  - iocs=1, iorw=latched rw, ioaddr=latched addr.
  - On write: dbus_oe=1, dbus_out=wdata.
  - On read: dbus_oe=0, and rdata captures dbus_in at the end of this cycle.
  - req changes are ignored from here on.
  - Go to DONE.
- DONE:
  - done[winner]=1 for one cycle, err=0.
  - rdata holds the captured byte (previous value on writes).
  - gnt clears at exit; pointer=winner; go to IDLE.
- Timing: minimum 4 cycles from req sampled in IDLE to the next IDLE.
  - req high at edge N → gnt at N+1 → iocs at N+2 → done at N+3.
- Requesters hold req/rw/addr/wdata stable until done. Keeping req high after done re-enters arbitration, and another waiting requester wins first.
- Simultaneous requests: the pointer guarantees no requester waits more than NUM_REQ-1 transactions.
- Outside BUS: iocs=0, dbus_oe=0, iorw=1. ioaddr holds its last value.

Optional Feature:
- Macro: SPART_ARB_TIMEOUT_EN.
- Defined:
  - A GRANT wait counter (clog2(TIMEOUT_CYC+1) bits) clears on entry to GRANT and increments each not-ready cycle.
  - When it reaches TIMEOUT_CYC while still not ready, skip BUS and go to DONE with err=1 and rdata=8'hFF.
  - The pointer advances as normal.
- Not defined: GRANT waits indefinitely; err is tied 0; no counter is present.

Test Plan:
- Reset, then req[0]=1, write addr 2 data 8'h80: gnt[0] at +1; iocs=1, iorw=0, ioaddr=2, dbus_oe=1, dbus_out=8'h80 at +2; done[0] at +3, err=0.
- req[0] and req[1] both held high for writes to addr 3: grants alternate 0,1,0,1; each done pulses exactly once per transaction.
- req[1] reads addr 0 with rda=0 for 10 cycles, then rda=1 while dbus_in=8'h5A: stays in GRANT, no iocs; one-cycle iocs follows rda; done[1] with rdata=8'h5A.
- req[0] writes addr 0 with tbr=0, then drops req after 3 cycles: returns to IDLE; no iocs, no done; a following req[0] still wins first.
- rst asserted during BUS: next cycle all outputs are at reset values; no done is emitted.
- With SPART_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, write addr 0 with tbr held 0: done with err=1, rdata=8'hFF, no iocs cycle; without the macro it waits more than 100 cycles with no done.
